// File: rtl/qspi_ram_responder_if.sv
// Quad-SPI bus bundle between the core's QSPI initiator and the RAM responder.
// The master modport is the initiator side; the slave modport is the memory side.
interface qspi_ram_responder_if;
    logic       qspi_clk;
    logic       qspi_select;
    logic [3:0] qspi_data_in;
    logic [3:0] qspi_data_out;
    logic       qspi_data_oe;
    logic       cmd_error;

    modport master (
        output qspi_clk,
        output qspi_select,
        output qspi_data_in,
        input  qspi_data_out,
        input  qspi_data_oe,
        input  cmd_error
    );

    modport slave (
        input  qspi_clk,
        input  qspi_select,
        input  qspi_data_in,
        output qspi_data_out,
        output qspi_data_oe,
        output cmd_error
    );
endinterface

// File: rtl/qspi_ram_responder.sv
// QSPI RAM responder: memory-side end of the quad-SPI bus on the RAM-A chip
// select. Serves quad write (0x38) and fast quad read (0xEB) from an internal
// byte array. The bus is oversampled on the system clock: all bus inputs are
// synchronized and qspi_clk edges are detected, so qspi_clk must be at most
// clock/4.
// Optional feature macro: QSPI_RESP_DEBUG_PORT_EN adds a registered memory
// inspection port (debug_addr / debug_data).
module qspi_ram_responder #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int DUMMY_CYCLES   = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    qspi_ram_responder_if.slave       qspi
`ifdef QSPI_RESP_DEBUG_PORT_EN
    ,
    input  logic [MEM_ADDR_WIDTH-1:0] debug_addr,
    output logic [7:0]                debug_data
`endif
);

    // Shift register is wide enough for the 8-bit command and the kept address bits.
    localparam int SHW = (MEM_ADDR_WIDTH > 8) ? MEM_ADDR_WIDTH : 8;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [7:0] CMD_WRITE  = 8'h38;
    localparam logic [7:0] CMD_READ   = 8'hEB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_reg;
    logic [1:0] sel_sync_reg;
    logic       clk_prev_reg;
    logic       sel_prev_reg;
    logic [3:0] data_s;
    logic       clk_s;
    logic       sel_s;
    logic       rise;
    logic       fall;

    // Two-flop synchronizers for qspi_clk and select, plus previous-value flops.
    // Select is reset to "selected" so a select held low across reset is not
    // mistaken for a fresh falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_reg <= 2'b00;
            sel_sync_reg <= 2'b00;
            clk_prev_reg <= 1'b0;
            sel_prev_reg <= 1'b0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[0], qspi.qspi_clk};
            sel_sync_reg <= {sel_sync_reg[0], qspi.qspi_select};
            clk_prev_reg <= clk_sync_reg[1];
            sel_prev_reg <= sel_sync_reg[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_data_sync
            logic [1:0] stage_reg;
            // Two-flop synchronizer for one data line.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    stage_reg <= 2'b00;
                end else begin
                    stage_reg <= {stage_reg[0], qspi.qspi_data_in[gi]};
                end
            end
            assign data_s[gi] = stage_reg[1];
        end
    endgenerate

    assign clk_s = clk_sync_reg[1];
    assign sel_s = sel_sync_reg[1];
    assign rise  = clk_s & ~clk_prev_reg;
    assign fall  = ~clk_s & clk_prev_reg;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_t                    state_reg,    state_next;
    logic [7:0]                cnt_reg,      cnt_next;
    logic [SHW-1:0]            shift_reg,    shift_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_reg,     addr_next;
    logic                      is_read_reg,  is_read_next;
    logic [3:0]                hi_nib_reg,   hi_nib_next;
    logic                      half_reg,     half_next;
    logic [3:0]                dout_reg,     dout_next;
    logic                      oe_reg,       oe_next;
    logic                      cmd_error_reg, cmd_error_next;
    logic [SHW-1:0]            shifted;
    logic                      mem_we;
    logic [7:0]                rd_data_reg;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            addr_reg      <= '0;
            is_read_reg   <= 1'b0;
            hi_nib_reg    <= '0;
            half_reg      <= 1'b0;
            dout_reg      <= '0;
            oe_reg        <= 1'b0;
            cmd_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            addr_reg      <= addr_next;
            is_read_reg   <= is_read_next;
            hi_nib_reg    <= hi_nib_next;
            half_reg      <= half_next;
            dout_reg      <= dout_next;
            oe_reg        <= oe_next;
            cmd_error_reg <= cmd_error_next;
        end
    end

    // Next-state logic: sample on detected rises, drive on detected falls;
    // deselect overrides everything, including an edge in the same clock.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        addr_next      = addr_reg;
        is_read_next   = is_read_reg;
        hi_nib_next    = hi_nib_reg;
        half_next      = half_reg;
        dout_next      = dout_reg;
        oe_next        = oe_reg;
        cmd_error_next = 1'b0;
        mem_we         = 1'b0;
        shifted        = {shift_reg[SHW-5:0], data_s};

        if (sel_s) begin
            state_next = ST_IDLE;
            oe_next    = 1'b0;
            cnt_next   = '0;
            half_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // Only a genuine high-to-low transition starts a transaction.
                    if (sel_prev_reg) begin
                        state_next = ST_CMD;
                        cnt_next   = '0;
                        half_next  = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        shift_next = shifted;
                        if (cnt_reg == 8'd1) begin
                            cnt_next = '0;
                            if (shifted[7:0] == CMD_WRITE) begin
                                state_next   = ST_ADDR;
                                is_read_next = 1'b0;
                            end else if (shifted[7:0] == CMD_READ) begin
                                state_next   = ST_ADDR;
                                is_read_next = 1'b1;
                            end else begin
                                state_next     = ST_IGNORE;
                                cmd_error_next = 1'b1;
                            end
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        shift_next = shifted;
                        if (cnt_reg == 8'd5) begin
                            cnt_next  = '0;
                            half_next = 1'b0;
                            // Upper address bits beyond the array size are dropped.
                            addr_next = shifted[MEM_ADDR_WIDTH-1:0];
                            if (!is_read_reg) begin
                                state_next = ST_WRITE;
                            end else if (DUMMY_CYCLES == 0) begin
                                state_next = ST_READ;
                            end else begin
                                state_next = ST_DUMMY;
                            end
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (cnt_reg == DUMMY_LAST) begin
                            cnt_next   = '0;
                            state_next = ST_READ;
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (rise) begin
                        if (!half_reg) begin
                            hi_nib_next = data_s;
                            half_next   = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            addr_next = addr_reg + MEM_ADDR_WIDTH'(1);
                            half_next = 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    // rd_data_reg tracks mem[addr_reg] one clock behind; falls
                    // are at least four clocks apart so it is always current.
                    if (fall) begin
                        oe_next = 1'b1;
                        if (!half_reg) begin
                            dout_next = rd_data_reg[7:4];
                            half_next = 1'b1;
                        end else begin
                            dout_next = rd_data_reg[3:0];
                            addr_next = addr_reg + MEM_ADDR_WIDTH'(1);
                            half_next = 1'b0;
                        end
                    end
                end
                ST_IGNORE: begin
                    state_next = ST_IGNORE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte array (not reset) with registered read
    // ------------------------------------------------------------------
    logic [7:0] mem [0:(2**MEM_ADDR_WIDTH)-1];

    // Commit a completed write byte and refresh the read data register.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_reg] <= {hi_nib_reg, data_s};
        end
        rd_data_reg <= mem[addr_reg];
    end

`ifdef QSPI_RESP_DEBUG_PORT_EN
    logic [7:0] debug_data_reg;

    // Registered inspection read; a same-clock write returns the old byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            debug_data_reg <= '0;
        end else begin
            debug_data_reg <= mem[debug_addr];
        end
    end

    assign debug_data = debug_data_reg;
`endif

    assign qspi.qspi_data_out = dout_reg;
    assign qspi.qspi_data_oe  = oe_reg;
    assign qspi.cmd_error     = cmd_error_reg;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Directed testbench for qspi_ram_responder: write/readback, unsupported
// command, partial write, address wrap, reset during a read, and (when
// QSPI_RESP_DEBUG_PORT_EN is defined) the debug port.
module tb_qspi_ram_responder;

    logic clock;
    logic reset;
    int   checks;
    int   passed;
    int   err_pulses;
    int   oe_clocks;

    logic [7:0] rd_byte [0:3];
    logic       rd_oe_all;
    logic       pre_oe;

    qspi_ram_responder_if intf ();

`ifdef QSPI_RESP_DEBUG_PORT_EN
    logic [7:0] debug_addr;
    logic [7:0] debug_data;
`endif

    qspi_ram_responder #(
        .MEM_ADDR_WIDTH (8),
        .DUMMY_CYCLES   (6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .qspi       (intf)
`ifdef QSPI_RESP_DEBUG_PORT_EN
        ,
        .debug_addr (debug_addr),
        .debug_data (debug_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cmd_error pulses and clocks with the output enable high.
    always @(negedge clock) begin
        if (intf.cmd_error)    err_pulses++;
        if (intf.qspi_data_oe) oe_clocks++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // One qspi_clk period (8 system clocks): drive the nibble while low,
    // sample the responder just before raising, then lower again.
    task automatic nib(input logic [3:0] n, output logic [3:0] d, output logic o);
        intf.qspi_data_in = n;
        repeat (4) @(negedge clock);
        d = intf.qspi_data_out;
        o = intf.qspi_data_oe;
        intf.qspi_clk = 1'b1;
        repeat (4) @(negedge clock);
        intf.qspi_clk = 1'b0;
    endtask

    task automatic start_txn(input logic [7:0] cmd, input logic [23:0] addr);
        logic [3:0] d;
        logic       o;
        intf.qspi_select = 1'b0;
        repeat (4) @(negedge clock);
        nib(cmd[7:4], d, o); pre_oe = pre_oe | o;
        nib(cmd[3:0], d, o); pre_oe = pre_oe | o;
        for (int i = 5; i >= 0; i--) begin
            nib(addr[i*4 +: 4], d, o);
            pre_oe = pre_oe | o;
        end
    endtask

    task automatic end_txn();
        intf.qspi_clk    = 1'b0;
        intf.qspi_select = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    task automatic write2(input logic [23:0] addr, input logic [7:0] b0, input logic [7:0] b1);
        logic [3:0] d;
        logic       o;
        start_txn(8'h38, addr);
        nib(b0[7:4], d, o); nib(b0[3:0], d, o);
        nib(b1[7:4], d, o); nib(b1[3:0], d, o);
        end_txn();
    endtask

    task automatic read_start(input logic [23:0] addr);
        logic [3:0] d;
        logic       o;
        start_txn(8'hEB, addr);
        for (int i = 0; i < 6; i++) begin
            nib(4'h0, d, o);
            pre_oe = pre_oe | o;
        end
    endtask

    task automatic read_bytes(input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        logic       o1;
        logic       o2;
        for (int i = 0; i < n; i++) begin
            nib(4'h0, hi, o1);
            nib(4'h0, lo, o2);
            rd_byte[i] = {hi, lo};
            rd_oe_all  = rd_oe_all & o1 & o2;
        end
    endtask

    initial begin
        logic [3:0] d;
        logic       o;
        int         e0;
        int         oe0;

        checks = 0; passed = 0; err_pulses = 0; oe_clocks = 0;
        pre_oe = 1'b0; rd_oe_all = 1'b1;
        reset = 1'b1;
        intf.qspi_clk = 1'b0;
        intf.qspi_select = 1'b1;
        intf.qspi_data_in = 4'h0;
`ifdef QSPI_RESP_DEBUG_PORT_EN
        debug_addr = 8'h00;
`endif
        repeat (3) @(negedge clock);
        check("reset_data_out", {28'h0, intf.qspi_data_out}, 32'h0);
        check("reset_oe", {31'h0, intf.qspi_data_oe}, 32'h0);
        check("reset_cmd_error", {31'h0, intf.cmd_error}, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        $display("reset released");

        // Write A5 3C at 0x10, read it back nibble by nibble.
        write2(24'h000010, 8'hA5, 8'h3C);
        $display("write 0x38 addr 000010 data A5 3C");
        pre_oe = 1'b0; rd_oe_all = 1'b1;
        read_start(24'h000010);
        read_bytes(2);
        end_txn();
        $display("read 0xEB addr 000010 -> %h %h", rd_byte[0], rd_byte[1]);
        check("rw_nib0", {28'h0, rd_byte[0][7:4]}, 32'hA);
        check("rw_nib1", {28'h0, rd_byte[0][3:0]}, 32'h5);
        check("rw_nib2", {28'h0, rd_byte[1][7:4]}, 32'h3);
        check("rw_nib3", {28'h0, rd_byte[1][3:0]}, 32'hC);
        check("rw_oe_before_data", {31'h0, pre_oe}, 32'h0);
        check("rw_oe_during_data", {31'h0, rd_oe_all}, 32'h1);
        check("rw_oe_after_deselect", {31'h0, intf.qspi_data_oe}, 32'h0);
        check("rw_no_cmd_error", err_pulses, 32'd0);

        // Unsupported command 0x9F followed by 8 more clocks.
        e0 = err_pulses; oe0 = oe_clocks;
        intf.qspi_select = 1'b0;
        repeat (4) @(negedge clock);
        nib(4'h9, d, o); nib(4'hF, d, o);
        for (int i = 0; i < 8; i++) nib(4'h0, d, o);
        end_txn();
        $display("cmd 0x9F + 8 clocks, cmd_error pulses %0d", err_pulses - e0);
        check("bad_cmd_error_once", err_pulses - e0, 32'd1);
        check("bad_cmd_oe_low", oe_clocks - oe0, 32'd0);
        rd_oe_all = 1'b1;
        read_start(24'h000010);
        read_bytes(1);
        end_txn();
        $display("read addr 000010 after bad cmd -> %h", rd_byte[0]);
        check("bad_cmd_mem_unchanged", {24'h0, rd_byte[0]}, 32'hA5);

        // Partial write: one nibble only, then deselect.
        write2(24'h000020, 8'h66, 8'h77);
        start_txn(8'h38, 24'h000020);
        nib(4'h7, d, o);
        end_txn();
        read_start(24'h000020);
        read_bytes(1);
        end_txn();
        $display("partial write 7 to 000020, read -> %h", rd_byte[0]);
        check("partial_write_discarded", {24'h0, rd_byte[0]}, 32'h66);

        // Wrap-around at the top of the 256-byte array.
        write2(24'h0000FF, 8'h11, 8'h22);
        read_start(24'h0001FF);
        read_bytes(2);
        end_txn();
        $display("wrap read 0001FF -> %h %h", rd_byte[0], rd_byte[1]);
        check("wrap_top_byte", {24'h0, rd_byte[0]}, 32'h11);
        check("wrap_read_next", {24'h0, rd_byte[1]}, 32'h22);
        read_start(24'h000000);
        read_bytes(1);
        end_txn();
        $display("read 000000 -> %h", rd_byte[0]);
        check("wrap_byte_zero", {24'h0, rd_byte[0]}, 32'h22);

        // Reset in the middle of a read data phase.
        read_start(24'h000010);
        nib(4'h0, d, o);
        check("midrst_first_nib", {28'h0, d}, 32'hA);
        reset = 1'b1;
        #1;
        check("midrst_oe_async", {31'h0, intf.qspi_data_oe}, 32'h0);
        check("midrst_data_async", {28'h0, intf.qspi_data_out}, 32'h0);
        @(negedge clock);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        end_txn();
        read_start(24'h000010);
        read_bytes(2);
        end_txn();
        $display("read after mid-read reset -> %h %h", rd_byte[0], rd_byte[1]);
        check("midrst_reread_b0", {24'h0, rd_byte[0]}, 32'hA5);
        check("midrst_reread_b1", {24'h0, rd_byte[1]}, 32'h3C);

`ifdef QSPI_RESP_DEBUG_PORT_EN
        write2(24'h000003, 8'h5A, 8'h00);
        debug_addr = 8'h03;
        @(negedge clock);
        $display("debug_addr 03 -> %h", debug_data);
        check("debug_data", {24'h0, debug_data}, 32'h5A);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
